// File: rtl/cal_sequencer.sv
// Convolution read sequencer: walks the output loop nest and issues IFM/weight BRAM
// word reads plus PE accumulate strobes. Optional cycle counter under CAL_SEQ_PERF_CNT_EN.
module cal_sequencer #(
    parameter int TOTAL_PE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cal_start,
    input  logic [3:0]  KERNEL_W,
    input  logic [7:0]  OFM_W,
    input  logic [7:0]  OFM_C,
    input  logic [7:0]  IFM_C,
    input  logic [7:0]  IFM_W,
    input  logic [1:0]  stride,
    input  logic        pe_ready,
    output logic        ifm_rd_en,
    output logic [31:0] ifm_rd_addr,
    output logic        wgt_rd_en,
    output logic [31:0] wgt_rd_addr,
    output logic        pe_acc_clr,
    output logic        pe_acc_last,
    output logic [7:0]  ofm_x,
    output logic [7:0]  ofm_y,
    output logic [7:0]  ofm_grp,
    output logic        done_compute,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [3:0]  k_q;
    logic [7:0]  ow_q, oc_q, ic_q, iw_q;
    logic [1:0]  st_q;
    logic [5:0]  icw;
    logic [3:0]  kx, ky;
    logic [7:0]  grp, ox, oy;
    logic        nest_done;
    logic        drain_cnt;

    // In IDLE the live inputs drive the datapath so the first beat issues on the start edge.
    logic [3:0]  cfg_k;
    logic [7:0]  cfg_ow, cfg_oc, cfg_ic, cfg_iw;
    logic [1:0]  cfg_st;
    logic [5:0]  cfg_cw;
    logic [8:0]  grp_n;
    logic        cfg_bad;

    always_comb begin
        cfg_k  = (state == S_IDLE) ? KERNEL_W : k_q;
        cfg_ow = (state == S_IDLE) ? OFM_W    : ow_q;
        cfg_oc = (state == S_IDLE) ? OFM_C    : oc_q;
        cfg_ic = (state == S_IDLE) ? IFM_C    : ic_q;
        cfg_iw = (state == S_IDLE) ? IFM_W    : iw_q;
        cfg_st = (state == S_IDLE) ? stride   : st_q;
        cfg_cw = 6'(cfg_ic >> 2);
        grp_n  = 9'((10'(cfg_oc) + 10'(TOTAL_PE - 1)) / 10'(TOTAL_PE));
        cfg_bad = (cfg_k == 4'd0) || (cfg_ow == 8'd0) || (cfg_oc == 8'd0) || (cfg_cw == 6'd0);
    end

    logic icw_last, kx_last, ky_last, grp_last, ox_last, oy_last, all_last;
    logic [5:0]  icw_nx;
    logic [3:0]  kx_nx, ky_nx;
    logic [7:0]  grp_nx, ox_nx, oy_nx;
    logic [31:0] iy, ix, cw32, ifm_addr_nx, wgt_addr_nx;
    logic        issue;

    always_comb begin
        icw_last = (icw == cfg_cw - 6'd1);
        kx_last  = (kx == cfg_k - 4'd1);
        ky_last  = (ky == cfg_k - 4'd1);
        grp_last = (9'(grp) == grp_n - 9'd1);
        ox_last  = (ox == cfg_ow - 8'd1);
        oy_last  = (oy == cfg_ow - 8'd1);
        all_last = icw_last && kx_last && ky_last && grp_last && ox_last && oy_last;

        // Odometer increment, icw fastest
        icw_nx = icw; kx_nx = kx; ky_nx = ky; grp_nx = grp; ox_nx = ox; oy_nx = oy;
        if (!icw_last) icw_nx = icw + 6'd1;
        else begin
            icw_nx = '0;
            if (!kx_last) kx_nx = kx + 4'd1;
            else begin
                kx_nx = '0;
                if (!ky_last) ky_nx = ky + 4'd1;
                else begin
                    ky_nx = '0;
                    if (!grp_last) grp_nx = grp + 8'd1;
                    else begin
                        grp_nx = '0;
                        if (!ox_last) ox_nx = ox + 8'd1;
                        else begin
                            ox_nx = '0;
                            oy_nx = oy + 8'd1;
                        end
                    end
                end
            end
        end

        cw32 = 32'(cfg_cw);
        iy   = 32'(oy) * 32'(cfg_st) + 32'(ky);
        ix   = 32'(ox) * 32'(cfg_st) + 32'(kx);
        ifm_addr_nx = (iy * 32'(cfg_iw) + ix) * cw32 + 32'(icw);
        wgt_addr_nx = ((32'(grp) * 32'(cfg_k) + 32'(ky)) * 32'(cfg_k) + 32'(kx)) * cw32 + 32'(icw);

        issue = cal_start && pe_ready &&
                (((state == S_IDLE) && !cfg_bad) || ((state == S_RUN) && !nest_done));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k_q <= '0; ow_q <= '0; oc_q <= '0; ic_q <= '0; iw_q <= '0; st_q <= '0;
            icw <= '0; kx <= '0; ky <= '0; grp <= '0; ox <= '0; oy <= '0;
            nest_done <= 1'b0; drain_cnt <= 1'b0;
            ifm_rd_en <= 1'b0; wgt_rd_en <= 1'b0;
            ifm_rd_addr <= '0; wgt_rd_addr <= '0;
            pe_acc_clr <= 1'b0; pe_acc_last <= 1'b0;
            ofm_x <= '0; ofm_y <= '0; ofm_grp <= '0;
            done_compute <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so the trailing issue block can override defaults.
            ifm_rd_en <= 1'b0;
            wgt_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cal_start) begin
                        k_q <= KERNEL_W; ow_q <= OFM_W; oc_q <= OFM_C;
                        ic_q <= IFM_C; iw_q <= IFM_W; st_q <= stride;
                        if (cfg_bad) begin
                            state        <= S_DONE;
                            done_compute <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (!cal_start) begin
                        state <= S_IDLE;
                        icw <= '0; kx <= '0; ky <= '0; grp <= '0; ox <= '0; oy <= '0;
                        nest_done <= 1'b0; drain_cnt <= 1'b0;
                        ifm_rd_addr <= '0; wgt_rd_addr <= '0;
                        pe_acc_clr <= 1'b0; pe_acc_last <= 1'b0;
                        ofm_x <= '0; ofm_y <= '0; ofm_grp <= '0;
                    end else if (state == S_RUN) begin
                        if (nest_done) state <= S_DRAIN;
                    end else begin
                        drain_cnt <= ~drain_cnt;
                        if (drain_cnt) begin
                            state        <= S_DONE;
                            done_compute <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!cal_start) begin
                        state        <= S_IDLE;
                        done_compute <= 1'b0;
                        icw <= '0; kx <= '0; ky <= '0; grp <= '0; ox <= '0; oy <= '0;
                        nest_done <= 1'b0; drain_cnt <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                ifm_rd_en   <= 1'b1;
                wgt_rd_en   <= 1'b1;
                ifm_rd_addr <= ifm_addr_nx;
                wgt_rd_addr <= wgt_addr_nx;
                pe_acc_clr  <= (ky == 4'd0) && (kx == 4'd0) && (icw == 6'd0);
                pe_acc_last <= ky_last && kx_last && icw_last;
                ofm_x       <= ox;
                ofm_y       <= oy;
                ofm_grp     <= grp;
                if (all_last) nest_done <= 1'b1;
                icw <= icw_nx; kx <= kx_nx; ky <= ky_nx;
                grp <= grp_nx; ox <= ox_nx; oy <= oy_nx;
            end
        end
    end

`ifdef CAL_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if ((state == S_IDLE) && cal_start && !cfg_bad) begin
            cycle_count <= '0;
        end else if (((state == S_RUN) || (state == S_DRAIN)) && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: doc/cal_sequencer.md
# cal_sequencer

Convolution read sequencer sitting directly downstream of `Control_unit`. It consumes `cal_start` and the registered layer configuration (`KERNEL_W_out`, `OFM_W_out`, `OFM_C_out`, `IFM_C_out`, `IFM_W_out`, `stride_out`). It walks the full output loop nest and issues 32-bit word read addresses to the IFM and weight BRAMs, plus accumulate-clear and accumulate-last strobes to the PE array. When the layer is finished it returns `done_compute`.

## Interface
- `TOTAL_PE`, 16: output channels computed in parallel per weight read group.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cal_start`  in  1  level request from `Control_unit`; held high during S_CAL.
- `KERNEL_W`  in  4  kernel width/height (square).
- `OFM_W`  in  8  output width/height (square).
- `OFM_C`  in  8  output channels.
- `IFM_C`  in  8  input channels; multiple of 4.
- `IFM_W`  in  8  input width/height, already padded.
- `stride`  in  2  convolution stride.
- `pe_ready`  in  1  PE array can accept a read beat; low stalls the sequencer.
- `ifm_rd_en`  out  1  IFM BRAM read strobe.
- `ifm_rd_addr`  out  32  IFM word address.
- `wgt_rd_en`  out  1  weight BRAM read strobe; identical timing to `ifm_rd_en`.
- `wgt_rd_addr`  out  32  weight word address.
- `pe_acc_clr`  out  1  qualifies the first beat of an output pixel/group.
- `pe_acc_last`  out  1  qualifies the last beat of an output pixel/group.
- `ofm_x`, `ofm_y`  out  8 each  output coordinate of the current beat.
- `ofm_grp`  out  8  output-channel group index of the current beat.
- `done_compute`  out  1  layer complete, to `Control_unit`.
- `cycle_count`  out  32  active-cycle counter (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: `cal_start`=1. Configuration is latched on this transition and ignored afterwards.
- IDLE → DONE directly if any latched `KERNEL_W`, `OFM_W`, `OFM_C` = 0 or `IFM_C`<4. No reads are issued.
- Loop nest, innermost first:
  - icw 0..IFM_C/4−1
  - kx 0..KERNEL_W−1
  - ky 0..KERNEL_W−1
  - grp 0..ceil(OFM_C/TOTAL_PE)−1
  - ox 0..OFM_W−1
  - oy 0..OFM_W−1
- IFM address: ((oy·stride+ky)·IFM_W + ox·stride+kx)·(IFM_C/4) + icw.
- Weight address: ((grp·KERNEL_W+ky)·KERNEL_W+kx)·(IFM_C/4) + icw.
- All arithmetic is unsigned 32-bit. `IFM_C[1:0]` is ignored.
- `pe_acc_clr`=1 on beats with ky=kx=icw=0.
- `pe_acc_last`=1 on beats with ky=kx=KERNEL_W−1 and icw=IFM_C/4−1.
- Both strobes are set together when the nest has a single beat.
- RUN → DRAIN after the final beat, i.e. the last value of every counter.
- DRAIN lasts 2 cycles, then → DONE.
- DONE: `done_compute`=1, held until `cal_start`=0, then → IDLE.
- `cal_start`=0 during RUN or DRAIN: abort to IDLE next cycle. `done_compute` stays 0 and all counters clear.
- `pe_ready`=0 during RUN:
  - counters hold;
  - `ifm_rd_en`/`wgt_rd_en` drop to 0 next cycle;
  - address, coordinate and strobe outputs hold their values.

## Timing
- Reset: state IDLE; every output is 0, including `cycle_count`.
- All outputs are registered.
- First `ifm_rd_en` appears 1 cycle after the clock edge that samples `cal_start`=1 in IDLE, given `pe_ready`=1.
- One beat per cycle with no stalls.
- Total beats = OFM_W²·ceil(OFM_C/TOTAL_PE)·KERNEL_W²·(IFM_C/4).
- `done_compute` rises 3 cycles after the last read beat (1 for the register, 2 for DRAIN).
- Read data from the BRAMs arrives 1 cycle after the strobe. The DRAIN length covers this data plus one PE accumulate cycle.
- Reset asserted mid-operation: return to IDLE immediately and asynchronously; outputs go to 0.

## Configuration
- `CAL_SEQ_PERF_CNT_EN` defined:
  - `cycle_count` clears on IDLE→RUN;
  - increments every cycle in RUN or DRAIN, stalls included;
  - holds in DONE and IDLE; saturates at 0xFFFFFFFF.
- Not defined: `cycle_count` is tied to 0 and no counter logic is present.

## Test plan
- Stride 1: KERNEL_W=3, IFM_W=4, IFM_C=4, OFM_W=2, OFM_C=16, stride=1, `pe_ready`=1.
  - 36 beats.
  - First pixel IFM addresses 0,1,2,4,5,6,8,9,10; weight addresses 0..8.
  - `pe_acc_clr` on beats 1, 10, 19, 28; `pe_acc_last` on beats 9, 18, 27, 36.
  - `done_compute` 3 cycles after beat 36.
- Stride 2: KERNEL_W=3, IFM_W=5, IFM_C=4, OFM_W=2, OFM_C=16, stride=2.
  - First beat of ox=1 has `ifm_rd_addr`=2.
  - First beat of oy=1, ox=0 has address 10.
- Stall: same setup as stride 1; drop `pe_ready` for 5 cycles at beat 4.
  - Beat 4 address (4) is held, no strobe during the stall.
  - Resumes at beat 5 address 5; total beats still 36.
- Abort/handshake:
  - Deassert `cal_start` at beat 10 → IDLE, `done_compute` never rises.
  - Normal completion with `cal_start` held → `done_compute` stays 1 until `cal_start`=0, then 0 the next cycle.
- Zero dimension: OFM_W=0 → DONE one cycle after start, zero read strobes.
- Grouping and perf counter: OFM_C=20, TOTAL_PE=16, KERNEL_W=1, OFM_W=1, IFM_C=8.
  - 4 beats; weight addresses 0, 1, 2, 3.
  - `ofm_grp` 0,0,1,1.
  - With `CAL_SEQ_PERF_CNT_EN`, `cycle_count`=6 in DONE.
